// File: rtl/dds_pkg.sv
// Shared definitions for the two-channel DDS sequencer: widths, the mid-scale
// value for a disabled channel and the ROM-read FSM state type.
package dds_pkg;

    localparam int unsigned ACC_W  = 24;   // phase accumulator width
    localparam int unsigned ADDR_W = 10;   // sine ROM address width
    localparam int unsigned DATA_W = 10;   // sine ROM data / sample width
    localparam int unsigned NCH    = 2;    // number of DDS channels

    // Sample value presented for a disabled channel
    localparam logic [DATA_W-1:0] MID = DATA_W'(512);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD0  = 2'd1,
        RD1  = 2'd2
    } state_t;

endpackage

// File: rtl/sine_rom_scheduler_if.sv
// Config write port of the DDS sequencer (valid/ready).
//   cfg_valid : write request            cfg_ready : write accepted when both high
//   cfg_ch    : target channel           cfg_sel   : 0 = tuning word, 1 = phase offset
//   cfg_data  : value written
interface sine_rom_scheduler_if;
    import dds_pkg::*;

    logic             cfg_valid;
    logic             cfg_ready;
    logic             cfg_ch;
    logic             cfg_sel;
    logic [ACC_W-1:0] cfg_data;

    modport master (output cfg_valid, cfg_ch, cfg_sel, cfg_data, input cfg_ready);
    modport slave  (input cfg_valid, cfg_ch, cfg_sel, cfg_data, output cfg_ready);

endinterface

// File: rtl/dds_phase_acc.sv
// One DDS channel: tuning-word and phase-offset registers, the phase
// accumulator and the offset adder. Exposes the top ADDR_W bits of the phase.
//   clk, rst_n : clock, async active-low reset
//   adv        : advance accumulator by the tuning word this edge
//   wr_tw      : load tuning word from wr_data
//   wr_off     : load phase offset from wr_data
//   addr_c     : combinational ROM address for the current phase
module dds_phase_acc
    import dds_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              adv,
    input  logic              wr_tw,
    input  logic              wr_off,
    input  logic [ACC_W-1:0]  wr_data,
    output logic [ADDR_W-1:0] addr_c
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] tw;
    logic [ACC_W-1:0] off;
    logic [ACC_W-1:0] phase;

    // Accumulator and config registers; all adds wrap modulo 2^ACC_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            tw  <= '0;
            off <= '0;
        end else begin
            if (adv)    acc <= acc + tw;
            if (wr_tw)  tw  <= wr_data;
            if (wr_off) off <= wr_data;
        end
    end

    assign phase  = acc + off;
    assign addr_c = phase[ACC_W-1 -: ADDR_W];

endmodule

// File: rtl/sine_rom_scheduler.sv
// Two-channel DDS sequencer sharing one combinational sine ROM. Each tick
// advances the enabled accumulators, reads the ROM for channel 0 then
// channel 1, and pulses out_valid once both samples are registered.
//   clk, rst_n        : clock, async active-low reset
//   tick              : sample strobe        ch_en    : per-channel enable
//   ovr_clr           : clears overrun       cfg      : config write port
//   rom_addr/rom_data : shared ROM bus (ROM lives outside)
//   sample0/sample1   : registered samples   out_valid: both samples updated
//   overrun           : sticky, tick seen while a read sequence was running
module sine_rom_scheduler
    import dds_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic [NCH-1:0]       ch_en,
    input  logic                 ovr_clr,
    sine_rom_scheduler_if.slave  cfg,
    output logic [ADDR_W-1:0]    rom_addr,
    input  logic [DATA_W-1:0]    rom_data,
    output logic [DATA_W-1:0]    sample0,
    output logic [DATA_W-1:0]    sample1,
    output logic                 out_valid,
    output logic                 overrun
);

    state_t            state;
    state_t            state_n;
    logic              start;
    logic              ld0;
    logic              ld1;
    logic              cfg_ready_c;
    logic              cfg_fire;
    logic [ADDR_W-1:0] ch_addr [NCH];

    assign cfg.cfg_ready = cfg_ready_c;
    assign cfg_fire      = cfg.cfg_valid && cfg_ready_c;

    // Per-channel phase generators
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        dds_phase_acc u_acc (
            .clk     (clk),
            .rst_n   (rst_n),
            .adv     (start && ch_en[g]),
            .wr_tw   (cfg_fire && (cfg.cfg_ch == 1'(g)) && !cfg.cfg_sel),
            .wr_off  (cfg_fire && (cfg.cfg_ch == 1'(g)) &&  cfg.cfg_sel),
            .wr_data (cfg.cfg_data),
            .addr_c  (ch_addr[g])
        );
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next state, ROM address mux and load strobes
    always_comb begin
        state_n     = state;
        rom_addr    = '0;
        start       = 1'b0;
        ld0         = 1'b0;
        ld1         = 1'b0;
        cfg_ready_c = 1'b0;
        case (state)
            IDLE: begin
                // A tick takes priority over a pending config write
                cfg_ready_c = !tick;
                if (tick) begin
                    state_n = RD0;
                    start   = 1'b1;
                end
            end
            RD0: begin
                state_n  = RD1;
                rom_addr = ch_addr[0];
                ld0      = 1'b1;
            end
            RD1: begin
                state_n  = IDLE;
                rom_addr = ch_addr[1];
                ld1      = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    // Sample registers, valid strobe and sticky overrun (set beats clear)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample0   <= '0;
            sample1   <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (ld0) sample0 <= ch_en[0] ? rom_data : MID;
            if (ld1) sample1 <= ch_en[1] ? rom_data : MID;
            out_valid <= ld1;
            if (tick && (state != IDLE)) overrun <= 1'b1;
            else if (ovr_clr)            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sine_rom_scheduler.sv
module tb_sine_rom_scheduler;
    import dds_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              tick = 1'b0;
    logic              ovr_clr = 1'b0;
    logic [NCH-1:0]    ch_en = '0;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] sample0;
    logic [DATA_W-1:0] sample1;
    logic              out_valid;
    logic              overrun;

    sine_rom_scheduler_if cfg_bus ();

    sine_rom_scheduler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .ch_en     (ch_en),
        .ovr_clr   (ovr_clr),
        .cfg       (cfg_bus.slave),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .sample0   (sample0),
        .sample1   (sample1),
        .out_valid (out_valid),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Stand-in ROM contents: any fixed address-dependent pattern will do
    function automatic logic [DATA_W-1:0] rom_fn(input logic [ADDR_W-1:0] a);
        logic [19:0] t;
        t = 20'(a) * 20'd37 + 20'd11;
        return DATA_W'(t ^ (20'(a) >> 3));
    endfunction

    assign rom_data = rom_fn(rom_addr);

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        tick = 1'b0; ovr_clr = 1'b0; cfg_bus.cfg_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic cfg_write(input logic ch, input logic sel, input logic [ACC_W-1:0] d);
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_ch    = ch;
        cfg_bus.cfg_sel   = sel;
        cfg_bus.cfg_data  = d;
        step();
        cfg_bus.cfg_valid = 1'b0;
    endtask

    // One tick from IDLE: check both ROM addresses and the valid-cycle samples
    task automatic tick_seq(input string nm, input int a0, input int a1, input int s0, input int s1);
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk({nm, "_addr0"}, 32'(rom_addr), a0);
        chk({nm, "_v_rd0"}, 32'(out_valid), 0);
        step();
        chk({nm, "_addr1"}, 32'(rom_addr), a1);
        chk({nm, "_v_rd1"}, 32'(out_valid), 0);
        step();
        chk({nm, "_valid"}, 32'(out_valid), 1);
        chk({nm, "_s0"}, 32'(sample0), s0);
        chk({nm, "_s1"}, 32'(sample1), s1);
        step();
        chk({nm, "_v_after"}, 32'(out_valid), 0);
    endtask

    typedef struct {
        logic [ACC_W-1:0] tw0;
        logic [ACC_W-1:0] off0;
        logic [ACC_W-1:0] tw1;
        logic [ACC_W-1:0] off1;
        logic [1:0]       en;
        int               a0;
        int               a1;
    } vec_t;

    vec_t tbl [6];

    // Random-phase reference model state
    logic [ACC_W-1:0]  m_acc [2];
    logic [ACC_W-1:0]  m_tw  [2];
    logic [ACC_W-1:0]  m_off [2];
    logic [ADDR_W-1:0] m_a0, m_a1, exp_addr;
    logic [DATA_W-1:0] exp_s0, exp_s1;
    logic              exp_valid, exp_ovr, exp_ready, idle;
    int                la;
    int                vc;

    initial begin
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_ch    = 1'b0;
        cfg_bus.cfg_sel   = 1'b0;
        cfg_bus.cfg_data  = '0;

        // One tick after reset; acc = tw for enabled channels, address = top 10 bits of acc+off
        tbl[0] = '{24'h004000, 24'h000000, 24'h010000, 24'h0C4000, 2'b01,    1,  49};
        tbl[1] = '{24'h004000, 24'h000000, 24'h004000, 24'h400000, 2'b11,    1, 257};
        tbl[2] = '{24'hFFC000, 24'h000000, 24'h7FFFFF, 24'h000001, 2'b11, 1023, 512};
        tbl[3] = '{24'h004000, 24'hFFC000, 24'h00C000, 24'h000000, 2'b11,    0,   3};
        tbl[4] = '{24'h123456, 24'h000000, 24'h00C000, 24'h800000, 2'b00,    0, 512};
        tbl[5] = '{24'h200000, 24'h0AB000, 24'h3FFFFF, 24'h000000, 2'b10,   42, 255};

        // Reset state
        step();
        chk("rst_s0", 32'(sample0), 0);
        chk("rst_s1", 32'(sample1), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_ovr", 32'(overrun), 0);
        chk("rst_addr", 32'(rom_addr), 0);
        rst_n = 1'b1;
        step();
        chk("rst_ready", 32'(cfg_bus.cfg_ready), 1);

        // Table vectors
        for (int i = 0; i < 6; i++) begin
            do_reset();
            cfg_write(1'b0, 1'b0, tbl[i].tw0);
            cfg_write(1'b0, 1'b1, tbl[i].off0);
            cfg_write(1'b1, 1'b0, tbl[i].tw1);
            cfg_write(1'b1, 1'b1, tbl[i].off1);
            ch_en = tbl[i].en;
            tick_seq($sformatf("tbl%0d", i), tbl[i].a0, tbl[i].a1,
                     tbl[i].en[0] ? 32'(rom_fn(ADDR_W'(tbl[i].a0))) : 32'(MID),
                     tbl[i].en[1] ? 32'(rom_fn(ADDR_W'(tbl[i].a1))) : 32'(MID));
        end

        // Four ticks counting up
        do_reset();
        cfg_write(1'b0, 1'b0, 24'h004000);
        ch_en = 2'b01;
        for (int n = 1; n <= 4; n++)
            tick_seq($sformatf("up%0d", n), n, 0, 32'(rom_fn(ADDR_W'(n))), 32'(MID));

        // Counting down via a negative tuning word
        do_reset();
        cfg_write(1'b0, 1'b0, 24'hFFC000);
        tick_seq("down1", 1023, 0, 32'(rom_fn(ADDR_W'(1023))), 32'(MID));
        tick_seq("down2", 1022, 0, 32'(rom_fn(ADDR_W'(1022))), 32'(MID));

        // Tick during RD0: overrun, single valid, no double advance, clear
        do_reset();
        cfg_write(1'b0, 1'b0, 24'h004000);
        ch_en = 2'b01;
        tick = 1'b1;
        step();
        chk("ovr_pre", 32'(overrun), 0);
        step();
        tick = 1'b0;
        chk("ovr_set", 32'(overrun), 1);
        vc = 0;
        for (int k = 0; k < 5; k++) begin
            if (out_valid) vc++;
            step();
        end
        chk("ovr_one_valid", 32'(vc), 1);
        tick_seq("ovr_next", 2, 0, 32'(rom_fn(ADDR_W'(2))), 32'(MID));
        chk("ovr_sticky", 32'(overrun), 1);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        chk("ovr_clr", 32'(overrun), 0);
        tick = 1'b1;
        step();
        ovr_clr = 1'b1;
        step();
        tick = 1'b0; ovr_clr = 1'b0;
        chk("ovr_set_wins", 32'(overrun), 1);
        step(); step(); step();
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        chk("ovr_clr2", 32'(overrun), 0);

        // Tick and config write in the same cycle
        do_reset();
        cfg_write(1'b0, 1'b0, 24'h004000);
        tick = 1'b1;
        cfg_bus.cfg_valid = 1'b1; cfg_bus.cfg_ch = 1'b0; cfg_bus.cfg_sel = 1'b0;
        cfg_bus.cfg_data = 24'h008000;
        #1;
        chk("stall_ready_tick", 32'(cfg_bus.cfg_ready), 0);
        step();
        tick = 1'b0;
        #1;
        chk("stall_ready_rd0", 32'(cfg_bus.cfg_ready), 0);
        chk("stall_old_tw", 32'(rom_addr), 1);
        step();
        chk("stall_ready_rd1", 32'(cfg_bus.cfg_ready), 0);
        step();
        chk("stall_ready_idle", 32'(cfg_bus.cfg_ready), 1);
        step();
        cfg_bus.cfg_valid = 1'b0;
        tick_seq("stall_new_tw", 3, 0, 32'(rom_fn(ADDR_W'(3))), 32'(MID));

        // Disabled channel holds its accumulator and outputs mid-scale
        do_reset();
        cfg_write(1'b0, 1'b0, 24'h004000);
        cfg_write(1'b1, 1'b0, 24'h004000);
        ch_en = 2'b11;
        tick_seq("dis_a", 1, 1, 32'(rom_fn(ADDR_W'(1))), 32'(rom_fn(ADDR_W'(1))));
        ch_en = 2'b01;
        tick_seq("dis_b", 2, 1, 32'(rom_fn(ADDR_W'(2))), 32'(MID));
        ch_en = 2'b11;
        tick_seq("dis_c", 3, 2, 32'(rom_fn(ADDR_W'(3))), 32'(rom_fn(ADDR_W'(2))));

        // Reset asserted during RD1 aborts the sequence
        tick = 1'b1;
        step();
        step();
        tick = 1'b0;
        chk("abort_ovr_pre", 32'(overrun), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_s0", 32'(sample0), 0);
        chk("abort_s1", 32'(sample1), 0);
        chk("abort_valid", 32'(out_valid), 0);
        chk("abort_ovr", 32'(overrun), 0);
        chk("abort_addr", 32'(rom_addr), 0);
        step();
        rst_n = 1'b1;
        vc = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (out_valid) vc++;
        end
        chk("abort_no_valid", 32'(vc), 0);
        chk("abort_ready", 32'(cfg_bus.cfg_ready), 1);

        // Random traffic against a timing-rule model
        do_reset();
        for (int i = 0; i < 2; i++) begin
            m_acc[i] = '0; m_tw[i] = '0; m_off[i] = '0;
        end
        la = -100;
        m_a0 = '0; m_a1 = '0; exp_addr = '0;
        exp_s0 = '0; exp_s1 = '0; exp_valid = 1'b0; exp_ovr = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            chk("rnd_valid", 32'(out_valid), 32'(exp_valid));
            chk("rnd_s0", 32'(sample0), 32'(exp_s0));
            chk("rnd_s1", 32'(sample1), 32'(exp_s1));
            chk("rnd_ovr", 32'(overrun), 32'(exp_ovr));
            chk("rnd_addr", 32'(rom_addr), 32'(exp_addr));

            tick    = ($urandom_range(0, 3) == 0);
            ovr_clr = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 7) == 0) ch_en = 2'($urandom);
            cfg_bus.cfg_valid = ($urandom_range(0, 2) == 0);
            cfg_bus.cfg_ch    = 1'($urandom);
            cfg_bus.cfg_sel   = 1'($urandom);
            cfg_bus.cfg_data  = 24'($urandom);
            #1;
            // Idle means no tick was accepted in the previous two cycles
            idle      = (c - la >= 3);
            exp_ready = idle && !tick;
            chk("rnd_ready", 32'(cfg_bus.cfg_ready), 32'(exp_ready));

            if (la == c - 1) exp_s0 = ch_en[0] ? rom_fn(m_a0) : MID;
            exp_valid = (la == c - 2);
            if (exp_valid) exp_s1 = ch_en[1] ? rom_fn(m_a1) : MID;
            if (tick && !idle) exp_ovr = 1'b1;
            else if (ovr_clr)  exp_ovr = 1'b0;
            if (cfg_bus.cfg_valid && exp_ready) begin
                if (cfg_bus.cfg_sel) m_off[cfg_bus.cfg_ch] = cfg_bus.cfg_data;
                else                 m_tw[cfg_bus.cfg_ch]  = cfg_bus.cfg_data;
            end
            if (tick && idle) begin
                for (int i = 0; i < 2; i++)
                    if (ch_en[i]) m_acc[i] = m_acc[i] + m_tw[i];
                la = c;
                m_a0 = ADDR_W'((m_acc[0] + m_off[0]) >> (ACC_W - ADDR_W));
                m_a1 = ADDR_W'((m_acc[1] + m_off[1]) >> (ACC_W - ADDR_W));
            end
            if (la == c)          exp_addr = m_a0;
            else if (la == c - 1) exp_addr = m_a1;
            else                  exp_addr = '0;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sine_rom_scheduler.md
# sine_rom_scheduler

Two-channel direct-digital-synthesis sequencer that time-shares the single combinational sine ROM (1024 × 10-bit) between two phase accumulators. It holds per-channel tuning words and phase offsets written through a valid/ready config port. On each sample tick it advances both accumulators, reads the ROM once per channel in consecutive cycles, and presents both samples together with a one-cycle valid strobe. It sits between the sample-rate timer and the DAC/output formatter, and owns the ROM address bus exclusively.

## Interface
- ACC_W, 24: phase accumulator width; ROM address is the top ADDR_W bits of the phase.
- ADDR_W, 10: ROM address width.
- DATA_W, 10: ROM data / sample width.
- MID, 512: sample value loaded for a disabled channel.
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- tick  in  1  sample strobe, one-cycle pulse.
- ch_en  in  2  per-channel enable; bit i = channel i.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  config write accepted when cfg_valid && cfg_ready.
- cfg_ch  in  1  target channel.
- cfg_sel  in  1  0 = tuning word, 1 = phase offset.
- cfg_data  in  ACC_W  value written.
- ovr_clr  in  1  clears overrun.
- rom_addr  out  ADDR_W  address to the shared ROM.
- rom_data  in  DATA_W  combinational ROM output for rom_addr.
- sample0, sample1  out  DATA_W  registered channel samples.
- out_valid  out  1  one-cycle pulse: both samples updated.
- overrun  out  1  sticky: tick arrived while busy.

## Operation
- FSM states: IDLE, RD0, RD1.
  - IDLE → RD0 on tick.
  - RD0 → RD1 unconditionally.
  - RD1 → IDLE unconditionally.
- On the edge leaving IDLE on tick: acc[i] <= acc[i] + tw[i] for each enabled channel. Disabled accumulators hold.
- Phase: phase[i] = acc[i] + off[i], modulo 2^ACC_W.
- Address: rom_addr = phase[i][ACC_W-1 -: ADDR_W], with i = 0 in RD0 and i = 1 in RD1. rom_addr = 0 in IDLE.
- End of RD0: sample0 <= ch_en[0] ? rom_data : MID.
- End of RD1: sample1 <= ch_en[1] ? rom_data : MID. out_valid <= 1 for the following cycle.
- Accumulator and offset adds wrap silently; there is no saturation.
- cfg_ready = (state == IDLE) && !tick. A write lands on the accepting edge and affects the next tick.
- Tick together with cfg_valid: tick wins, cfg_ready is 0, and the config write stalls.
- Tick in RD0 or RD1: the tick is dropped, overrun <= 1, and the accumulators are untouched.
- Tick in the same cycle as ovr_clr: overrun set wins.
- ch_en is sampled at each use; changing it mid-sequence affects only later reads.

## Timing
- Tick high at edge k → RD0 during cycle k+1 → RD1 during cycle k+2 → out_valid high during cycle k+3.
- Latency from tick to valid is 3 cycles.
- Minimum tick spacing is 3 cycles; a tick in the out_valid cycle is legal.
- Reset (asynchronous, any state):
  - state = IDLE.
  - acc, tw, off = 0.
  - sample0 = sample1 = 0.
  - out_valid = 0, overrun = 0, rom_addr = 0.
  - cfg_ready returns to 1 once tick = 0.
- Reset mid-sequence aborts the read. No out_valid is produced, and no partial sample update survives.

## Structure
- Shared package dds_pkg contains:
  - state enum {IDLE, RD0, RD1}.
  - NCH = 2.
  - Default ACC_W, ADDR_W, DATA_W, MID.
- Sub-module dds_phase_acc, one instance per channel. It holds the tw/off registers, the accumulator and the phase adder, and exposes the ADDR_W address.
- The top level holds the FSM, ROM mux, sample registers and overrun logic. The ROM stays outside this block.

## Test plan
- Reset, then write tw0 = 0x004000 and enable ch0. Issue 4 ticks → rom_addr in RD0 reads 1, 2, 3, 4, and sample0 = ROM[1..4] with out_valid 3 cycles after each tick.
- Write tw0 = tw1 = 0x004000, off1 = 0x400000, enable both. One tick → RD0 addr 1, RD1 addr 257, and sample1 = ROM[257].
- Write tw0 = 0xFFC000 (acc starts at 0). Ticks → addresses 1023, 1022 …; separately, acc = 0xFFC000 with tw = 0x004000 → addr wraps to 0.
- Tick in RD0 → overrun = 1, accumulator not double-advanced, exactly one out_valid. Then ovr_clr → overrun = 0.
- tick and cfg_valid in the same cycle → cfg_ready = 0. Write accepted in the first IDLE cycle without tick, and the new tw applies from the next tick only.
- Disable ch1 and tick → sample1 = 512, acc1 frozen. Assert rst_n = 0 during RD1 → all outputs 0 and no out_valid.
